// File: rtl/ws2812_chain_if.sv
// rtl/ws2812_chain_if.sv - host bus of the multi-string WS2812 driver
interface ws2812_chain_if #(
   parameter int LED_W        = 3,
   parameter int CH_W         = 1,
   parameter int NUM_CHANNELS = 2
);
   logic [23:0]             rgb_data;
   logic [LED_W-1:0]        led_num;
   logic [CH_W-1:0]         chan;
   logic                    write;
   logic                    start;
   logic                    busy;
   logic [NUM_CHANNELS-1:0] data;

   modport master (output rgb_data, led_num, chan, write, start, input busy, data);
   modport slave  (input rgb_data, led_num, chan, write, start, output busy, data);
endinterface

// File: rtl/ws2812_chain.sv
// rtl/ws2812_chain.sv - N-string WS2812 driver with frame buffer; option macro WS2812_AUTO_REFRESH_EN
module ws2812_chain #(
   parameter int NUM_LEDS     = 8,
   parameter int NUM_CHANNELS = 2,
   parameter int BIT_CYC      = 15,
   parameter int T0H_CYC      = 4,
   parameter int T1H_CYC      = 8,
   parameter int RESET_CYC    = 600
) (
   input logic           clk,
   input logic           reset,
   ws2812_chain_if.slave bus
);
   localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int CYC_W = $clog2(BIT_CYC);
   localparam int LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

   localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);
   localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BIT_CYC - 1);
   localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RESET_CYC - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] BIT_HI = 3'd2;
   localparam logic [2:0] BIT_LO = 3'd3;
   localparam logic [2:0] LATCH  = 3'd4;

   logic [23:0]             frame_mem [NUM_CHANNELS][NUM_LEDS];
   logic [23:0]             shreg [NUM_CHANNELS];
   logic [2:0]              state;
   logic [CYC_W-1:0]        cyc;
   logic [4:0]              bit_cnt;
   logic [LED_W-1:0]        led_idx;
   logic [LAT_W-1:0]        lat_cnt;
   logic                    busy_q;
   logic [NUM_CHANNELS-1:0] data_q;
   logic                    wr_in_range;

   assign wr_in_range = (int'(bus.led_num) < NUM_LEDS) && (int'(bus.chan) < NUM_CHANNELS);
   assign bus.busy    = busy_q;
   assign bus.data    = data_q;

   // host writes land in the frame buffer at any time; out-of-range indices are dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++)
            for (int l = 0; l < NUM_LEDS; l++)
               frame_mem[c][l] <= '0;
      end else if (bus.write && wr_in_range) begin
         frame_mem[bus.chan][bus.led_num] <= bus.rgb_data;
      end
   end

   // frame sequencer: common bit timing for all strings, word reload merged into the last
   // cycle of the previous bit so periods run back to back, then the latch gap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy_q  <= 1'b0;
         data_q  <= '0;
         cyc     <= '0;
         bit_cnt <= '0;
         led_idx <= '0;
         lat_cnt <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) shreg[c] <= '0;
      end else begin
         case (state)
            IDLE: begin
               data_q <= '0;
               if (bus.start) state <= LOAD;
            end
            LOAD: begin
               busy_q  <= 1'b1;
               data_q  <= '1;
               cyc     <= '0;
               bit_cnt <= 5'd23;
               led_idx <= '0;
               state   <= BIT_HI;
               for (int c = 0; c < NUM_CHANNELS; c++) shreg[c] <= frame_mem[c][0];
            end
            BIT_HI, BIT_LO: begin
               if (cyc == LAST_CYC) begin
                  cyc <= '0;
                  if (bit_cnt == 5'd0) begin
                     if (led_idx == LAST_LED) begin
                        state   <= LATCH;
                        data_q  <= '0;
                        lat_cnt <= '0;
                     end else begin
                        led_idx <= led_idx + 1'b1;
                        bit_cnt <= 5'd23;
                        data_q  <= '1;
                        state   <= BIT_HI;
                        for (int c = 0; c < NUM_CHANNELS; c++)
                           shreg[c] <= frame_mem[c][led_idx + 1'b1];
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     data_q  <= '1;
                     state   <= BIT_HI;
                     for (int c = 0; c < NUM_CHANNELS; c++)
                        shreg[c] <= {shreg[c][22:0], 1'b0};
                  end
               end else begin
                  cyc   <= cyc + 1'b1;
                  state <= ((int'(cyc) + 1) < T1H_CYC) ? BIT_HI : BIT_LO;
                  for (int c = 0; c < NUM_CHANNELS; c++)
                     data_q[c] <= (int'(cyc) + 1) < (shreg[c][23] ? T1H_CYC : T0H_CYC);
               end
            end
            LATCH: begin
               if (lat_cnt == LAST_LAT) begin
`ifdef WS2812_AUTO_REFRESH_EN
                  // restart without a bubble so the refresh period is exactly one frame
                  data_q  <= '1;
                  cyc     <= '0;
                  bit_cnt <= 5'd23;
                  led_idx <= '0;
                  state   <= BIT_HI;
                  for (int c = 0; c < NUM_CHANNELS; c++) shreg[c] <= frame_mem[c][0];
`else
                  data_q <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
`endif
               end else begin
                  data_q  <= '0;
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            default: begin
               data_q <= '0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812_chain.sv
// tb/tb_ws2812_chain.sv - directed self-checking bench for ws2812_chain
module tb_ws2812_chain;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   logic [23:0] exp_mem [2][3][8];
   int          hi_len [3][192];

   bit          inj_en;
   int          inj_cyc;
   int          inj_ch;
   int          inj_led;
   logic [23:0] inj_word;
   bit          inj_start;

   ws2812_chain_if #(.LED_W(3), .CH_W(1), .NUM_CHANNELS(2)) if1 ();
   ws2812_chain_if #(.LED_W(3), .CH_W(2), .NUM_CHANNELS(3)) if2 ();

   ws2812_chain #(.NUM_LEDS(8), .NUM_CHANNELS(2)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
   ws2812_chain #(.NUM_LEDS(5), .NUM_CHANNELS(3), .RESET_CYC(40)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_bus(input bit sel, input bit wr, input bit st, input int ch, input int led,
                          input logic [23:0] word);
      if (!sel) begin
         if1.write = wr; if1.start = st; if1.chan = 1'(ch); if1.led_num = 3'(led); if1.rgb_data = word;
      end else begin
         if2.write = wr; if2.start = st; if2.chan = 2'(ch); if2.led_num = 3'(led); if2.rgb_data = word;
      end
   endtask

   function automatic logic [2:0] get_data(input bit sel);
      return sel ? if2.data : {1'b0, if1.data};
   endfunction

   function automatic logic get_busy(input bit sel);
      return sel ? if2.busy : if1.busy;
   endfunction

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 3; c++)
            for (int l = 0; l < 8; l++)
               exp_mem[s][c][l] = 24'h0;
   endtask

   task automatic host_write(input bit sel, input int ch, input int led, input logic [23:0] word,
                             input bit stored);
      @(negedge clk); set_bus(sel, 1'b1, 1'b0, ch, led, word);
      @(negedge clk); set_bus(sel, 1'b0, 1'b0, 0, 0, 24'h0);
      if (stored) exp_mem[sel][ch][led] = word;
   endtask

   // launches one frame, records every bit period and the latch gap, then checks it
   task automatic run_frame(input bit sel, input string name, input bit wr_with_start, input int ch,
                            input int led, input logic [23:0] word);
      int nl, nc, rst_cyc, dcyc, shape_err, busy_err, extra_busy, i, p;
      logic [2:0] d, prev, first_d, mask;
      logic first_b;
      logic [23:0] obs;
      nl = sel ? 5 : 8; nc = sel ? 3 : 2; rst_cyc = sel ? 40 : 600; dcyc = nl * 24 * 15;
      mask = sel ? 3'b111 : 3'b011;
      shape_err = 0; busy_err = 0; extra_busy = 0; prev = 3'b0; first_d = 3'b0; first_b = 1'b0;
      for (int c = 0; c < 3; c++) for (int q = 0; q < 192; q++) hi_len[c][q] = 0;
      @(negedge clk); set_bus(sel, wr_with_start, 1'b1, ch, led, word);
      if (wr_with_start) exp_mem[sel][ch][led] = word;
      @(negedge clk); set_bus(sel, 1'b0, 1'b0, 0, 0, 24'h0);
      n_cmp++;
      if (get_busy(sel) !== 1'b0) begin
         n_bad++; $display("FAIL %s busy_at_start_edge: got %b expected 0", name, get_busy(sel));
      end
      for (int t = 0; t < dcyc + rst_cyc; t++) begin
         @(negedge clk);
         if (inj_en && t == inj_cyc + 1) set_bus(sel, 1'b0, 1'b0, 0, 0, 24'h0);
         d = get_data(sel);
         if (t == 0) begin first_d = d; first_b = get_busy(sel); end
         if (get_busy(sel) !== 1'b1) busy_err++;
         if (t < dcyc) begin
            i = t % 15; p = t / 15;
            for (int c = 0; c < nc; c++) begin
               if (i == 0 && d[c] !== 1'b1) shape_err++;
               else if (i > 0 && d[c] === 1'b1 && prev[c] !== 1'b1) shape_err++;
               if (d[c] === 1'b1) hi_len[c][p]++;
            end
            prev = d;
         end else if (d !== 3'b000) shape_err++;
         if (inj_en && t == inj_cyc) set_bus(sel, 1'b1, inj_start, inj_ch, inj_led, inj_word);
      end
      @(negedge clk);
      n_cmp++;
      if (get_busy(sel) !== 1'b0) begin
         n_bad++; $display("FAIL %s busy_fall: got %b expected 0", name, get_busy(sel));
      end
      repeat (20) begin
         @(negedge clk);
         if (get_busy(sel) !== 1'b0) extra_busy++;
      end
      n_cmp++;
      if (extra_busy !== 0) begin
         n_bad++; $display("FAIL %s idle_after_frame: busy cycles %0d expected 0", name, extra_busy);
      end
      n_cmp++;
      if (first_b !== 1'b1 || first_d !== mask) begin
         n_bad++; $display("FAIL %s first_edge: busy %b data %b expected 1 %b", name, first_b, first_d, mask);
      end
      for (int c = 0; c < nc; c++)
         for (int q = 0; q < nl * 24; q++)
            if (hi_len[c][q] != 4 && hi_len[c][q] != 8) shape_err++;
      n_cmp++;
      if (shape_err !== 0) begin
         n_bad++; $display("FAIL %s pulse_shape: errors %0d expected 0", name, shape_err);
      end
      n_cmp++;
      if (busy_err !== 0) begin
         n_bad++; $display("FAIL %s busy_during_frame: low cycles %0d expected 0", name, busy_err);
      end
      for (int c = 0; c < nc; c++)
         for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < 24; b++) obs[23-b] = (hi_len[c][l*24+b] == 8);
            n_cmp++;
            if (obs !== exp_mem[sel][c][l]) begin
               n_bad++;
               $display("FAIL %s word ch%0d led%0d: got %06h expected %06h", name, c, l, obs, exp_mem[sel][c][l]);
            end
         end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_bus(1'b0, 1'b0, 1'b0, 0, 0, 24'h0);
      set_bus(1'b1, 1'b0, 1'b0, 0, 0, 24'h0);
      inj_en = 1'b0;
      clear_model();
      #12;
      n_cmp++;
      if (if1.busy !== 1'b0 || if1.data !== 2'b00) begin
         n_bad++; $display("FAIL reset_dut1: busy %b data %b expected 0 00", if1.busy, if1.data);
      end
      n_cmp++;
      if (if2.busy !== 1'b0 || if2.data !== 3'b000) begin
         n_bad++; $display("FAIL reset_dut2: busy %b data %b expected 0 000", if2.busy, if2.data);
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (if1.busy !== 1'b0 || if1.data !== 2'b00) begin
         n_bad++; $display("FAIL post_reset_idle: busy %b data %b expected 0 00", if1.busy, if1.data);
      end
   endtask

   task automatic test_zero_frame();
      run_frame(1'b0, "zero_frame", 1'b0, 0, 0, 24'h0);
   endtask

   task automatic test_single_word();
      host_write(1'b0, 0, 0, 24'hFF0000, 1'b1);
      run_frame(1'b0, "single_word", 1'b0, 0, 0, 24'h0);
   endtask

   task automatic test_dropped_write();
      host_write(1'b1, 0, 4, 24'hA5A5A5, 1'b1);
      host_write(1'b1, 2, 0, 24'h800001, 1'b1);
      run_frame(1'b1, "drop_base", 1'b0, 0, 0, 24'h0);
      host_write(1'b1, 0, 6, 24'hFFFFFF, 1'b0);
      host_write(1'b1, 3, 1, 24'hFFFFFF, 1'b0);
      run_frame(1'b1, "drop_after", 1'b0, 0, 0, 24'h0);
   endtask

   task automatic test_write_during_busy();
      inj_en = 1'b1; inj_cyc = 100; inj_ch = 1; inj_led = 7; inj_word = 24'h000001; inj_start = 1'b1;
      exp_mem[0][1][7] = 24'h000001;
      run_frame(1'b0, "write_during_busy", 1'b0, 0, 0, 24'h0);
      inj_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      run_frame(1'b0, "write_with_start", 1'b1, 1, 0, 24'h00FF00);
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk); set_bus(1'b0, 1'b0, 1'b1, 0, 0, 24'h0);
      @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 0, 0, 24'h0);
      repeat (1082) @(negedge clk);
      n_cmp++;
      if (if1.data !== 2'b11 || if1.busy !== 1'b1) begin
         n_bad++; $display("FAIL led3_bit_hi: busy %b data %b expected 1 11", if1.busy, if1.data);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (if1.data !== 2'b00 || if1.busy !== 1'b0) begin
         n_bad++; $display("FAIL async_reset_mid_frame: busy %b data %b expected 0 00", if1.busy, if1.data);
      end
      @(negedge clk); reset = 1'b0;
      clear_model();
      run_frame(1'b0, "post_reset_dut1", 1'b0, 0, 0, 24'h0);
      run_frame(1'b1, "post_reset_dut2", 1'b0, 0, 0, 24'h0);
   endtask

   task automatic test_auto_refresh();
      int drops;
      logic [1:0] d_end, d_restart;
      drops = 0; d_end = 2'b11; d_restart = 2'b00;
      @(negedge clk); set_bus(1'b0, 1'b0, 1'b1, 0, 0, 24'h0);
      @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 0, 0, 24'h0);
      for (int t = 0; t < 2 * 3480 + 20; t++) begin
         @(negedge clk);
         if (if1.busy !== 1'b1) drops++;
         if (t == 3479) d_end = if1.data;
         if (t == 3480) d_restart = if1.data;
      end
      n_cmp++;
      if (drops !== 0) begin
         n_bad++; $display("FAIL auto_refresh_busy: low cycles %0d expected 0", drops);
      end
      n_cmp++;
      if (d_end !== 2'b00 || d_restart !== 2'b11) begin
         n_bad++; $display("FAIL auto_refresh_restart: end %b restart %b expected 00 11", d_end, d_restart);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
`ifdef WS2812_AUTO_REFRESH_EN
      test_auto_refresh();
`else
      test_zero_frame();
      test_single_word();
      test_dropped_write();
      test_write_during_busy();
      test_back_to_back();
      test_reset_mid_frame();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ws2812_chain.md
# ws2812_chain

Multi-channel, parametrised WS2812 string driver: generalises the single-output `ws2812` to N independent LED strings of configurable length, each with an on-chip frame buffer. The host writes 24-bit colour words per channel/LED, then issues `start`. All channels are transmitted bit-synchronously in parallel, followed by a latch (reset) gap. Sits behind the harness wishbone/GPIO glue like the other user projects; outputs drive IO pads directly.

## Interface

Parameters:
- `NUM_LEDS`, 8, LEDs per string (≥1)
- `NUM_CHANNELS`, 2, number of parallel strings (≥1)
- `BIT_CYC`, 15, clocks per bit period (1.25 µs @ 12 MHz)
- `T0H_CYC`, 4, high time for a 0 bit
- `T1H_CYC`, 8, high time for a 1 bit
- `RESET_CYC`, 600, latch gap in clocks (50 µs @ 12 MHz)
- Derived: `LED_W = max(1, $clog2(NUM_LEDS))`, `CH_W = max(1, $clog2(NUM_CHANNELS))`
- Legal only if 0 < T0H_CYC < T1H_CYC < BIT_CYC

Ports:
- `clk`  in  1  system clock (12 MHz nominal)
- `reset`  in  1  asynchronous, active-high reset
- `rgb_data`  in  24  colour word; bit 23 transmitted first (host packs GRB)
- `led_num`  in  LED_W  LED index for write
- `chan`  in  CH_W  channel index for write
- `write`  in  1  single-cycle strobe: store `rgb_data` at [chan][led_num]
- `start`  in  1  single-cycle strobe: transmit one frame
- `busy`  out  1  high while a frame (incl. latch gap) is in progress
- `data`  out  NUM_CHANNELS  serial line per string

## Operation

- Buffer: NUM_CHANNELS×NUM_LEDS×24 flops, cleared to 0 on reset.
- Write: on a `write` edge, word stored if `led_num < NUM_LEDS` and `chan < NUM_CHANNELS`; otherwise silently dropped. Writes are accepted at any time, including while busy.
- FSM states: IDLE, LOAD, BIT_HI, BIT_LO, LATCH.
  - IDLE: `busy`=0, `data`=0. `start` → LOAD.
  - LOAD: copy word [ch][led_idx] into each channel's 24-bit shift register; bit counter := 23; → BIT_HI.
  - BIT_HI: per channel, `data[c]`=1 for T0H_CYC or T1H_CYC cycles depending on its MSB; counter over BIT_CYC runs common to all channels.
  - BIT_LO: `data[c]`=0 for the remainder of BIT_CYC. At period end: shift; if bit counter=0 then (if last LED → LATCH else led_idx++ → LOAD) else decrement → BIT_HI.
  - LATCH: all `data`=0 for RESET_CYC cycles → IDLE.
- LOAD is merged into the last cycle of the previous bit (no bubble): bit periods are back-to-back, exactly BIT_CYC each.
- `start` while busy: ignored. `start` and `write` in same cycle: write is visible in that frame.
- Write to an LED already loaded in the current frame: takes effect next frame.
- Reset mid-frame: `data`→0, `busy`→0, buffer cleared, FSM→IDLE, asynchronously.

## Timing

- Reset values: `data`=0, `busy`=0.
- `start` sampled at edge k: `busy`=1 and all `data`=1 from edge k+1 (first high phase begins).
- Frame length: NUM_LEDS×24×BIT_CYC data cycles + RESET_CYC latch cycles; `busy` falls at edge k+1+that total.
- `data` is registered (glitch-free), all channels change on the same edge.
- Write latency: stored at the `write` edge; readable by LOAD in the next cycle.

## Configuration

- `WS2812_AUTO_REFRESH_EN` defined: on leaving LATCH the FSM goes directly to LOAD (continuous refresh, `busy` stays 1 until reset); `start` still launches from IDLE after reset.
- Undefined: LATCH → IDLE; one frame per `start`.

## Test plan

- Reset asserted mid-cycle → `data`=0, `busy`=0 immediately; post-reset frame transmits all-zero words (every high pulse 4 cycles).
- Write ch0/led0=0xFF0000, start (defaults) → `data[0]` first 8 pulses high 8 cycles/low 7, rest high 4/low 11; `data[1]` all high 4; `busy` high 8×24×15+600=3480 cycles.
- Write led_num=9 (NUM_LEDS=8, LED_W=3 → use NUM_LEDS=5, led_num=6) → word dropped; frame identical to prior.
- During busy in LED 0: write ch1/led7=0x000001, pulse start → second start ignored; led7 on ch1 ends with one 8-cycle pulse in this frame.
- Reset asserted during BIT_HI of LED 3 → outputs 0 same cycle, buffer reads back 0 next frame.
- With `WS2812_AUTO_REFRESH_EN`: single start → frames repeat every 3480 cycles, `busy` never drops; without: `busy` drops after 3480.
